// File: rtl/sensor_calib_pkg.sv
// Shared definitions for the delay-line sensor calibration controller.
// Holds the sweep FSM state type and the width and thermometer helpers
// used by sensor_calib_ctrl and sens_popcount_acc.
package sensor_calib_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StSample,
    StEval,
    StDone,
    StFail
  } calib_state_e;

  // Widest thermometer field the helper can produce.
  localparam int unsigned ThermMax = 256;

  // Ceiling log2, never less than 1 so it is always usable as a vector width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // n ones, LSB-first; callers size-cast the result down to their field width.
  function automatic logic [ThermMax-1:0] therm(input int unsigned n);
    logic [ThermMax-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ThermMax; i++) r[i] = (i < n);
    return r;
  endfunction

endpackage

// File: rtl/sens_popcount_acc.sv
// Two-stage popcount pipeline with accumulator.
// Stage 1 registers the raw sensor word every cycle, stage 2 registers its
// Hamming weight, and the accumulator adds stage 2 while enabled.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   clr    clear the accumulator (has priority over en)
//   en     add the stage-2 popcount into the accumulator
//   sensor raw sensor word
//   acc    accumulated Hamming weight
module sens_popcount_acc
  import sensor_calib_pkg::*;
#(
  parameter int unsigned SENSOR_W   = 32,
  parameter int unsigned N_AVG_LOG2 = 4,
  localparam int unsigned PW        = clog2(SENSOR_W + 1),
  localparam int unsigned AW        = PW + N_AVG_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [SENSOR_W-1:0] sensor,
  output logic [AW-1:0]       acc
);

  logic [SENSOR_W-1:0] sample_q;
  logic [PW-1:0]       pop_d;
  logic [PW-1:0]       pop_q;
  logic [AW-1:0]       acc_q;

  always_comb begin
    pop_d = '0;
    for (int unsigned i = 0; i < SENSOR_W; i++) pop_d = pop_d + PW'(sample_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q <= '0;
      pop_q    <= '0;
      acc_q    <= '0;
    end else begin
      sample_q <= sensor;
      pop_q    <= pop_d;
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= acc_q + AW'(pop_q);
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/sensor_calib_ctrl.sv
// Delay-line sensor calibration controller.
// Sweeps the coarse (outer) and fine (inner) thermometer delay settings, averages
// 2^N_AVG_LOG2 sensor Hamming weights per setting and stops at the first setting
// whose average lies in [TARGET_LO, TARGET_HI]. On exhaustion the configuration
// is reloaded to all zeros and fail_o is raised.
// Ports:
//   clk_i         clock (aes_clk)
//   rst_n         synchronous active-low reset
//   start_i       one-cycle pulse starting a sweep (ignored unless idle)
//   sensor_i      raw sensor word
//   idc_idf_o     {fine thermometer, coarse thermometer} configuration
//   idc_idf_en_o  one-cycle load strobe for idc_idf_o
//   busy_o        sweep in progress
//   done_o        calibration hit (level, held until next start)
//   fail_o        sweep exhausted (level, held until next start)
//   coarse_cnt_o  ones in the coarse field
//   fine_cnt_o    ones in the fine field
//   avg_o         last evaluated average Hamming weight
module sensor_calib_ctrl
  import sensor_calib_pkg::*;
#(
  parameter int unsigned SENSOR_W    = 32,
  parameter int unsigned COARSE_BITS = 32,
  parameter int unsigned FINE_BITS   = 96,
  parameter int unsigned N_AVG_LOG2  = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TARGET_LO   = 12,
  parameter int unsigned TARGET_HI   = 20
) (
  input  logic                                clk_i,
  input  logic                                rst_n,
  input  logic                                start_i,
  input  logic [SENSOR_W-1:0]                 sensor_i,
  output logic [COARSE_BITS+FINE_BITS-1:0]    idc_idf_o,
  output logic                                idc_idf_en_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                fail_o,
  output logic [clog2(COARSE_BITS+1)-1:0]     coarse_cnt_o,
  output logic [clog2(FINE_BITS+1)-1:0]       fine_cnt_o,
  output logic [clog2(SENSOR_W+1)-1:0]        avg_o
);

  localparam int unsigned CW     = clog2(COARSE_BITS + 1);
  localparam int unsigned FW     = clog2(FINE_BITS + 1);
  localparam int unsigned PW     = clog2(SENSOR_W + 1);
  localparam int unsigned AW     = PW + N_AVG_LOG2;
  localparam int unsigned CfgW   = COARSE_BITS + FINE_BITS;
  // Sampling window plus two cycles of pipeline fill.
  localparam int unsigned SmpCyc = (1 << N_AVG_LOG2) + 2;
  localparam int unsigned SmpW   = clog2(SmpCyc);
  localparam int unsigned StW    = clog2(SETTLE_CYC + 1);

  localparam logic [CW-1:0]   CoarseMax  = CW'(COARSE_BITS);
  localparam logic [FW-1:0]   FineMax    = FW'(FINE_BITS);
  localparam logic [PW-1:0]   TgtLo      = PW'(TARGET_LO);
  localparam logic [PW-1:0]   TgtHi      = PW'(TARGET_HI);
  localparam logic [StW-1:0]  SettleLast = StW'(SETTLE_CYC - 1);
  localparam logic [SmpW-1:0] SmpLast    = SmpW'(SmpCyc - 1);
  localparam logic [SmpW-1:0] SmpFill    = SmpW'(2);

  calib_state_e    state_q;
  logic [CW-1:0]   coarse_q;
  logic [FW-1:0]   fine_q;
  logic [CfgW-1:0] cfg_q;
  logic            cfg_en_q;
  logic            busy_q;
  logic            done_q;
  logic            fail_q;
  logic [PW-1:0]   avg_q;
  logic [StW-1:0]  settle_cnt_q;
  logic [SmpW-1:0] samp_cnt_q;

  logic [CfgW-1:0] cfg_next;
  logic [AW-1:0]   acc;
  logic [PW-1:0]   avg_w;
  logic            acc_clr;
  logic            acc_en;

  always_comb begin
    cfg_next = {FINE_BITS'(therm(32'(fine_q))), COARSE_BITS'(therm(32'(coarse_q)))};
  end

  // Accumulator is cleared while entering SETTLE; it only adds once the
  // two pipeline stages hold samples taken inside SAMPLE.
  assign acc_clr = (state_q == StApply);
  assign acc_en  = (state_q == StSample) && (samp_cnt_q >= SmpFill);
  assign avg_w   = PW'(acc >> N_AVG_LOG2);

  sens_popcount_acc #(
    .SENSOR_W   (SENSOR_W),
    .N_AVG_LOG2 (N_AVG_LOG2)
  ) u_popcount_acc (
    .clk    (clk_i),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .sensor (sensor_i),
    .acc    (acc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      coarse_q     <= '0;
      fine_q       <= '0;
      cfg_q        <= '0;
      cfg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      avg_q        <= '0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
    end else begin
      cfg_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            coarse_q <= '0;
            fine_q   <= '0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            avg_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StApply;
          end
        end
        StApply: begin
          cfg_q    <= cfg_next;
          cfg_en_q <= 1'b1;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            state_q      <= StSample;
          end else begin
            settle_cnt_q <= settle_cnt_q + StW'(1);
          end
        end
        StSample: begin
          if (samp_cnt_q == SmpLast) begin
            state_q <= StEval;
          end else begin
            samp_cnt_q <= samp_cnt_q + SmpW'(1);
          end
        end
        StEval: begin
          avg_q <= avg_w;
          if ((avg_w >= TgtLo) && (avg_w <= TgtHi)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else if ((coarse_q == CoarseMax) && (fine_q == FineMax)) begin
            // Park the sensor at the minimum delay after an unsuccessful sweep.
            coarse_q <= '0;
            fine_q   <= '0;
            cfg_q    <= '0;
            cfg_en_q <= 1'b1;
            fail_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StFail;
          end else begin
            if (fine_q == FineMax) begin
              fine_q   <= '0;
              coarse_q <= coarse_q + CW'(1);
            end else begin
              fine_q <= fine_q + FW'(1);
            end
            state_q <= StApply;
          end
        end
        StDone, StFail: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign idc_idf_o    = cfg_q;
  assign idc_idf_en_o = cfg_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;
  assign coarse_cnt_o = coarse_q;
  assign fine_cnt_o   = fine_q;
  assign avg_o        = avg_q;

endmodule

// File: doc/sensor_calib_ctrl.md
Name: sensor_calib_ctrl

Overview:
- Calibration controller for the delay-line sensor.
- Sweeps the sensor's coarse/fine initial-delay configuration (the 128-bit IDC_IDF word and its load enable), averages the sensor's Hamming weight at each setting, and stops at the first setting whose average falls in a target window.
- Sits between the control FSM (start/status) and sensor_wrapper_top (configuration), in the aes_clk domain.
- Lets measurement firmware calibrate the sensor without a host-driven sweep.

Parameters:
- SENSOR_W, 32: sensor output width used for the popcount.
- COARSE_BITS, 32: coarse thermometer width; idc_idf_o[COARSE_BITS-1:0].
- FINE_BITS, 96: fine thermometer width; idc_idf_o[COARSE_BITS+FINE_BITS-1:COARSE_BITS].
- N_AVG_LOG2, 4: samples averaged per setting = 2^N_AVG_LOG2.
- SETTLE_CYC, 16: idle cycles after each config load before sampling (≥1).
- TARGET_LO, 12: lower bound of accepted average Hamming weight, inclusive.
- TARGET_HI, 20: upper bound of accepted average Hamming weight, inclusive.

Ports:
- clk_i  in  1  clock (aes_clk).
- rst_n  in  1  reset; **synchronous, active-low**.
- start_i  in  1  one-cycle pulse; begin a sweep.
- sensor_i  in  SENSOR_W  raw sensor word, sampled every cycle.
- idc_idf_o  out  COARSE_BITS+FINE_BITS  {fine thermometer, coarse thermometer}.
- idc_idf_en_o  out  1  one-cycle load strobe for idc_idf_o.
- busy_o  out  1  sweep in progress.
- done_o  out  1  calibration succeeded (level).
- fail_o  out  1  sweep exhausted without a hit (level).
- coarse_cnt_o  out  clog2(COARSE_BITS+1)  number of ones in the coarse field.
- fine_cnt_o  out  clog2(FINE_BITS+1)  number of ones in the fine field.
- avg_o  out  clog2(SENSOR_W+1)  last evaluated average Hamming weight.

Behaviour:
- Reset (rst_n=0 at a clk_i edge):
  - state IDLE; all outputs 0.
  - A reset applied mid-sweep aborts it immediately; no en strobe is issued.
- Thermometer encoding:
  - Coarse field has coarse_cnt ones, LSB-first; fine field likewise with fine_cnt.
  - idc_idf_o is registered and changes only in the cycle that idc_idf_en_o=1.
- Sweep order: coarse_cnt 0..COARSE_BITS (outer loop), fine_cnt 0..FINE_BITS (inner loop). The inner count resets to 0 when the outer count increments.
- States:
  - IDLE: on start_i go to APPLY with counts = 0; clear done_o, fail_o, avg_o; set busy_o. If start_i is not asserted, stay in IDLE.
  - APPLY (1 cycle): drive idc_idf_o from the counts; idc_idf_en_o=1; go to SETTLE.
  - SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE:
    - Pipeline: stage 1 registers sensor_i; stage 2 registers popcount; the accumulator adds stage 2.
    - Accumulate exactly 2^N_AVG_LOG2 consecutive samples; the state lasts 2^N_AVG_LOG2+2 cycles (pipeline fill).
    - Accumulator width is clog2(SENSOR_W+1)+N_AVG_LOG2; it never overflows.
  - EVAL (1 cycle):
    - avg = acc >> N_AVG_LOG2 (truncating); load avg_o.
    - If TARGET_LO ≤ avg ≤ TARGET_HI: go to DONE.
    - Else, if the last setting (COARSE_BITS, FINE_BITS) has just been evaluated: go to FAIL.
    - Else: advance the counts and go to APPLY.
  - DONE: busy_o=0; done_o=1; config and counts hold the hit setting; return to IDLE. Outputs stay held until the next start_i.
  - FAIL:
    - Counts ← 0; drive all-zero config with one idc_idf_en_o strobe.
    - busy_o=0; fail_o=1; return to IDLE. avg_o holds the last average.
- start_i while busy_o=1 is ignored.
- start_i in the same cycle as DONE/FAIL is ignored; the restart is honoured from IDLE on the next start pulse.
- Accumulator and settle counter clear on entry to SETTLE and SAMPLE respectively.
- Timing per setting: 1+SETTLE_CYC+2^N_AVG_LOG2+2+1 cycles.
- Latency: start_i → first idc_idf_en_o is 2 cycles.

Decomposition:
- Package sensor_calib_pkg:
  - State enum (IDLE, APPLY, SETTLE, SAMPLE, EVAL, DONE, FAIL).
  - Width-helper functions: clog2, thermometer encoder.
- One natural sub-module: sens_popcount_acc (2-stage popcount pipeline plus accumulator; clear/enable inputs).

Test Plan:
All scenarios use COARSE_BITS=4, FINE_BITS=4, SENSOR_W=8, N_AVG_LOG2=2, SETTLE_CYC=3, TARGET 3..5 unless stated.
- Hit on first setting: sensor_i=8'h0F constant; start → single en strobe with idc_idf_o=0; done_o after 11 cycles; avg_o=4; counts 0/0.
- Sweep hit:
  - Model sensor_i=8'hFF, changing to 8'h07 once coarse_cnt=2 is loaded.
  - Required: en strobes for coarse 0,1 × fine 0..4, then a hit at coarse=2, fine=0.
  - Required: idc_idf_o=8'b0000_0011; avg_o=3; done_o=1.
- Exhaustion: sensor_i=0 → 25 evaluations, then fail_o=1; final en strobe with idc_idf_o=0; avg_o=0; counts 0.
- Averaging truncation: sensor_i alternates 8'h07/8'h3F (pop 3,6) → acc=18, avg=4, hit.
- Reset mid-SAMPLE: rst_n low for 1 cycle → next cycle all outputs 0, state IDLE; a subsequent start sweeps from 0/0.
- Start while busy: second start_i during SETTLE is ignored; the sweep sequence is unchanged; one done_o.
